// File: rtl/target_select_ctrl_pkg.sv
// target_select_pkg: shared defaults, ID type and step direction for the target selector and command framer.
package target_select_pkg;
    localparam int ID_W = 6;
    localparam int CH_W = 2;
    localparam logic [CH_W-1:0] CHANNEL = 2'b11;
    localparam int DEBOUNCE_CYCLES = 50000;
    typedef logic [ID_W-1:0] target_id_t;
    typedef enum logic [1:0] {NONE, UP, DOWN} step_dir_t;
endpackage

// File: rtl/target_select_ctrl_if.sv
// target_select_if: button/lock inputs and command-word outputs of the target selector.
interface target_select_if #(
    parameter int ID_W = target_select_pkg::ID_W,
    parameter int CH_W = target_select_pkg::CH_W
);
    logic button_up;
    logic button_down;
    logic lock;
    logic [ID_W+CH_W-1:0] data_out;
    logic [ID_W-1:0] target_id;
    logic changed;
    modport master(output button_up, button_down, lock, input data_out, target_id, changed);
    modport slave(input button_up, button_down, lock, output data_out, target_id, changed);
endinterface

// File: rtl/target_select_ctrl_debouncer.sv
// button_debouncer: 2-flop synchroniser plus stable-count debounce; press pulses on a debounced rise.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = target_select_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press,
    output logic held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            held  <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], button};
            press <= 1'b0;
            if (sync[1] == held)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                held  <= ~held;
                press <= ~held;
            end else
                cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/target_select_ctrl.sv
// target_select_ctrl: up/down button target-ID selector with auto-repeat, lock and change strobe.
module target_select_ctrl #(
    parameter int ID_W = target_select_pkg::ID_W,
    parameter int CH_W = target_select_pkg::CH_W,
    parameter logic [CH_W-1:0] CHANNEL = target_select_pkg::CHANNEL,
    parameter int MIN_ID = 1,
    parameter int MAX_ID = 20,
    parameter int RESET_ID = 1,
    parameter int DEBOUNCE_CYCLES = target_select_pkg::DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE = 5000000,
    parameter bit WRAP = 1'b1
) (
    input logic clk,
    input logic rst_n,
    target_select_if.slave bus
);
    import target_select_pkg::*;
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    logic [1:0] press, held, rep;
    logic [ID_W-1:0] id_q, id_d;
    logic changed_q;
    step_dir_t dir;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst_n(rst_n), .button(bus.button_up), .press(press[0]), .held(held[0])
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst_n(rst_n), .button(bus.button_down), .press(press[1]), .held(held[1])
    );

    // A nonzero count marks a hold armed by its own press; the other button going high disarms it for good.
    for (genvar g = 0; g < 2; g++) begin : g_rep
        logic [RW-1:0] cnt;
        logic rpt;
        logic go;
        logic fire;
        assign go = held[g] && !held[1-g] && (cnt != '0 || press[g]);
        assign fire = REPEAT_DELAY > 0 && go && cnt == RW'(rpt ? REPEAT_RATE : REPEAT_DELAY);
        assign rep[g] = fire;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                cnt <= '0;
                rpt <= 1'b0;
            end else begin
                cnt <= go ? (fire ? RW'(1) : cnt + 1'b1) : '0;
                rpt <= go && (rpt || fire);
            end
    end

    always_comb
        dir = lock_steps() ? NONE :
              ((press[0] || rep[0]) && !held[1]) ? UP :
              ((press[1] || rep[1]) && !held[0]) ? DOWN : NONE;

    function automatic logic lock_steps();
        return bus.lock;
    endfunction

    always_comb
        id_d = dir == UP   ? (id_q == ID_W'(MAX_ID) ? (WRAP ? ID_W'(MIN_ID) : id_q) : id_q + 1'b1) :
               dir == DOWN ? (id_q == ID_W'(MIN_ID) ? (WRAP ? ID_W'(MAX_ID) : id_q) : id_q - 1'b1) :
               id_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            id_q      <= ID_W'(RESET_ID);
            changed_q <= 1'b0;
        end else begin
            id_q      <= id_d;
            changed_q <= id_d != id_q;
        end

    assign bus.target_id = id_q;
    assign bus.changed   = changed_q;
    assign bus.data_out  = {id_q, CHANNEL};
endmodule

// File: tb/tb_target_select_ctrl.sv
// tb_target_select_ctrl: scenario tasks plus change-strobe scoreboards for a wrapping and a saturating selector.
module tb_target_select_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [5:0] cur = 6'd1;
    logic [5:0] cur_s = 6'd1;
    logic [5:0] exp_q[$];
    logic [5:0] exp_s[$];
    logic [5:0] e_m, e_s;

    always #5 clk = ~clk;

    target_select_if #(.ID_W(6), .CH_W(2)) bus ();
    target_select_if #(.ID_W(6), .CH_W(2)) bus_s ();

    target_select_ctrl #(.ID_W(6), .CH_W(2), .CHANNEL(2'b11), .MIN_ID(1), .MAX_ID(20), .RESET_ID(1),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .WRAP(1'b1))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    target_select_ctrl #(.ID_W(6), .CH_W(2), .CHANNEL(2'b11), .MIN_ID(1), .MAX_ID(20), .RESET_ID(1),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .WRAP(1'b0))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    function automatic logic [5:0] nxt(input logic [5:0] id, input bit up, input bit wrap);
        if (up) return (id == 6'd20) ? (wrap ? 6'd1 : id) : 6'(id + 6'd1);
        return (id == 6'd1) ? (wrap ? 6'd20 : id) : 6'(id - 6'd1);
    endfunction

    always @(negedge clk)
        if (rst_n && bus.changed) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL change_unexpected: target_id=%0d, no change expected", bus.target_id);
            end else begin
                e_m = exp_q.pop_front();
                if (bus.data_out !== {e_m, 2'b11}) begin
                    n_fail++;
                    $display("FAIL change_value: data_out=0x%02h expected 0x%02h", bus.data_out, {e_m, 2'b11});
                end
            end
        end

    always @(negedge clk)
        if (rst_n && bus_s.changed) begin
            n_checks++;
            if (exp_s.size() == 0) begin
                n_fail++;
                $display("FAIL sat_change_unexpected: target_id=%0d, no change expected", bus_s.target_id);
            end else begin
                e_s = exp_s.pop_front();
                if (bus_s.data_out !== {e_s, 2'b11}) begin
                    n_fail++;
                    $display("FAIL sat_change_value: data_out=0x%02h expected 0x%02h", bus_s.data_out, {e_s, 2'b11});
                end
            end
        end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(3);
        n_checks++;
        if (bus.target_id !== 6'd1) begin n_fail++; $display("FAIL reset_id: target_id=%0d expected 1", bus.target_id); end
        n_checks++;
        if (bus.changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: changed=%b expected 0", bus.changed); end
        n_checks++;
        if (bus.data_out !== 8'h07) begin n_fail++; $display("FAIL reset_data: data_out=0x%02h expected 0x07", bus.data_out); end
        n_checks++;
        if (bus_s.target_id !== 6'd1) begin n_fail++; $display("FAIL reset_sat_id: target_id=%0d expected 1", bus_s.target_id); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 4; i++) begin
            bus.button_up = 1'b1;
            cyc(3);
            bus.button_up = 1'b0;
            cyc(3);
        end
        cyc(6);
        n_checks++;
        if (bus.target_id !== cur) begin n_fail++; $display("FAIL glitch_id: target_id=%0d expected %0d", bus.target_id, cur); end
    endtask

    task automatic test_single_press();
        cur = nxt(cur, 1'b1, 1'b1);
        exp_q.push_back(cur);
        bus.button_up = 1'b1;
        cyc(6);
        n_checks++;
        if (bus.target_id !== 6'd1) begin n_fail++; $display("FAIL press_early: target_id=%0d expected 1 at edge 6", bus.target_id); end
        bus.button_up = 1'b0;
        cyc(1);
        n_checks++;
        if (bus.target_id !== 6'd2) begin n_fail++; $display("FAIL press_step: target_id=%0d expected 2 at edge 7", bus.target_id); end
        n_checks++;
        if (bus.changed !== 1'b1) begin n_fail++; $display("FAIL press_changed: changed=%b expected 1", bus.changed); end
        n_checks++;
        if (bus.data_out !== 8'h0B) begin n_fail++; $display("FAIL press_data: data_out=0x%02h expected 0x0B", bus.data_out); end
        cyc(1);
        n_checks++;
        if (bus.changed !== 1'b0) begin n_fail++; $display("FAIL press_pulse_width: changed=%b expected 0", bus.changed); end
        cyc(12);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL press_pending: %0d changes outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit dirs [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            cur = nxt(cur, dirs[i], 1'b1);
            exp_q.push_back(cur);
            if (dirs[i]) bus.button_up = 1'b1;
            else bus.button_down = 1'b1;
            cyc(7);
            bus.button_up = 1'b0;
            bus.button_down = 1'b0;
            n_checks++;
            if (bus.target_id !== cur) begin n_fail++; $display("FAIL wrap_step%0d: target_id=%0d expected %0d", i, bus.target_id, cur); end
            cyc(12);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_pending: %0d changes outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_saturate();
        repeat (19) begin
            cur_s = nxt(cur_s, 1'b1, 1'b0);
            exp_s.push_back(cur_s);
        end
        bus_s.button_up = 1'b1;
        cyc(7);
        n_checks++;
        if (bus_s.target_id !== 6'd2) begin n_fail++; $display("FAIL sat_first: target_id=%0d expected 2", bus_s.target_id); end
        cyc(61);
        n_checks++;
        if (bus_s.target_id !== 6'd20) begin n_fail++; $display("FAIL sat_reach_max: target_id=%0d expected 20", bus_s.target_id); end
        cyc(3);
        n_checks++;
        if (bus_s.changed !== 1'b0) begin n_fail++; $display("FAIL sat_repeat_changed: changed=%b expected 0", bus_s.changed); end
        cyc(20);
        bus_s.button_up = 1'b0;
        cyc(12);
        bus_s.button_up = 1'b1;
        cyc(7);
        bus_s.button_up = 1'b0;
        n_checks++;
        if (bus_s.target_id !== 6'd20 || bus_s.changed !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_press: target_id=%0d changed=%b expected 20 and 0", bus_s.target_id, bus_s.changed);
        end
        cyc(12);
        n_checks++;
        if (exp_s.size() != 0) begin n_fail++; $display("FAIL sat_pending: %0d changes outstanding expected 0", exp_s.size()); end
    endtask

    task automatic test_auto_repeat();
        logic [5:0] base;
        base = cur;
        repeat (6) begin
            cur = nxt(cur, 1'b1, 1'b1);
            exp_q.push_back(cur);
        end
        bus.button_up = 1'b1;
        cyc(7);
        n_checks++;
        if (bus.target_id !== 6'(base + 6'd1)) begin n_fail++; $display("FAIL repeat_press: target_id=%0d expected %0d", bus.target_id, base + 6'd1); end
        cyc(9);
        n_checks++;
        if (bus.target_id !== 6'(base + 6'd1)) begin n_fail++; $display("FAIL repeat_early: target_id=%0d expected %0d", bus.target_id, base + 6'd1); end
        cyc(1);
        n_checks++;
        if (bus.target_id !== 6'(base + 6'd2)) begin n_fail++; $display("FAIL repeat_first: target_id=%0d expected %0d", bus.target_id, base + 6'd2); end
        cyc(8);
        bus.button_up = 1'b0;
        cyc(4);
        n_checks++;
        if (bus.target_id !== cur) begin n_fail++; $display("FAIL repeat_last: target_id=%0d expected %0d", bus.target_id, cur); end
        cyc(20);
        n_checks++;
        if (bus.target_id !== cur) begin n_fail++; $display("FAIL repeat_release: target_id=%0d expected %0d", bus.target_id, cur); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL repeat_pending: %0d changes outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_both();
        bus.button_up = 1'b1;
        bus.button_down = 1'b1;
        cyc(15);
        bus.button_down = 1'b0;
        cyc(25);
        bus.button_up = 1'b0;
        cyc(12);
        n_checks++;
        if (bus.target_id !== cur) begin n_fail++; $display("FAIL both_id: target_id=%0d expected %0d", bus.target_id, cur); end
    endtask

    task automatic test_lock();
        bus.lock = 1'b1;
        bus.button_up = 1'b1;
        cyc(7);
        bus.button_up = 1'b0;
        n_checks++;
        if (bus.target_id !== cur) begin n_fail++; $display("FAIL lock_hold: target_id=%0d expected %0d", bus.target_id, cur); end
        cyc(12);
        bus.lock = 1'b0;
        cyc(2);
        n_checks++;
        if (bus.target_id !== cur) begin n_fail++; $display("FAIL lock_no_queue: target_id=%0d expected %0d", bus.target_id, cur); end
        cur = nxt(cur, 1'b1, 1'b1);
        exp_q.push_back(cur);
        bus.button_up = 1'b1;
        cyc(7);
        bus.button_up = 1'b0;
        n_checks++;
        if (bus.target_id !== cur) begin n_fail++; $display("FAIL lock_release: target_id=%0d expected %0d", bus.target_id, cur); end
        cyc(12);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL lock_pending: %0d changes outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_hold();
        cur = nxt(cur, 1'b1, 1'b1);
        exp_q.push_back(cur);
        bus.button_up = 1'b1;
        cyc(7);
        n_checks++;
        if (bus.target_id !== 6'd9) begin n_fail++; $display("FAIL rst_hold_pre: target_id=%0d expected 9", bus.target_id); end
        cyc(5);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.target_id !== 6'd1 || bus.changed !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold_async: target_id=%0d changed=%b expected 1 and 0", bus.target_id, bus.changed);
        end
        cur = 6'd1;
        cyc(2);
        rst_n = 1'b1;
        cur = nxt(cur, 1'b1, 1'b1);
        exp_q.push_back(cur);
        cyc(6);
        n_checks++;
        if (bus.target_id !== 6'd1) begin n_fail++; $display("FAIL rst_hold_requalify: target_id=%0d expected 1 at edge 6", bus.target_id); end
        cyc(1);
        n_checks++;
        if (bus.target_id !== 6'd2 || bus.changed !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold_step: target_id=%0d changed=%b expected 2 and 1", bus.target_id, bus.changed);
        end
        bus.button_up = 1'b0;
        cyc(20);
        n_checks++;
        if (exp_q.size() != 0 || bus.target_id !== 6'd2) begin
            n_fail++;
            $display("FAIL rst_hold_final: target_id=%0d pending=%0d expected 2 and 0", bus.target_id, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        bus.button_up = 1'b0;
        bus.button_down = 1'b0;
        bus.lock = 1'b0;
        bus_s.button_up = 1'b0;
        bus_s.button_down = 1'b0;
        bus_s.lock = 1'b0;
        test_reset();
        test_glitch();
        test_single_press();
        test_wrap();
        test_saturate();
        test_auto_repeat();
        test_both();
        test_lock();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/target_select_ctrl.md
Name: target_select_ctrl

Overview:
- Selects the target machine ID from two push-buttons (up/down) and drives the 8-bit-style command word `{target_id, channel}` to the downstream sender.
- Parametrised successor to the fixed 1..20 selector. Adds:
  - configurable ID range, widths, channel code and debounce length;
  - input synchronisers;
  - hold-to-auto-repeat;
  - wrap or saturate mode;
  - a lock input;
  - a one-cycle change strobe.
- Sits between the board button pins and the UART/command framing logic.

Parameters:
- ID_W, 6, width of target_id field.
- CH_W, 2, width of channel field.
- CHANNEL, 2'b11, constant channel code in the low bits of data_out.
- MIN_ID, 1, lowest selectable ID.
- MAX_ID, 20, highest selectable ID (MIN_ID <= MAX_ID < 2**ID_W).
- RESET_ID, 1, ID after reset (MIN_ID..MAX_ID).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (>= 1).
- REPEAT_DELAY, 25000000, held cycles before the first auto-repeat step; 0 disables auto-repeat.
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat steps (>= 1).
- WRAP, 1, 1 = wrap MAX<->MIN, 0 = saturate at the limits.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- button_up, input, 1, raw asynchronous increment button, active-high.
- button_down, input, 1, raw asynchronous decrement button, active-high.
- lock, input, 1, synchronous; while 1, all steps are discarded.
- data_out, output, ID_W+CH_W, `{target_id, CHANNEL}`.
- target_id, output, ID_W, current selection.
- changed, output, 1, one-cycle pulse in the cycle target_id takes a new value.

Behaviour:
- **Reset (rst_n=0, async):**
  - target_id=RESET_ID; changed=0; data_out={RESET_ID,CHANNEL}.
  - Synchronisers, debounce counters, debounced levels and repeat counters all clear to 0.
  - Release is synchronous to clk. Reset asserted mid-debounce or mid-hold discards that progress; a button still held at release must re-qualify through full debounce.
- **Synchronisers:** each button passes a 2-flop synchroniser.
- **Debounce, per button:**
  - Counter increments while the synchronised level differs from the debounced level, and clears to 0 whenever they match.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES causes no change.
- **Press event:** rising edge of a debounced level. The step is applied on the next edge.
  - Latency from button rising (stable) to target_id update: DEBOUNCE_CYCLES+3 clk edges.
- **Step rules:**
  - Up: target_id+1; if target_id==MAX_ID, result is MIN_ID (WRAP=1) or unchanged (WRAP=0).
  - Down: symmetric at MIN_ID, going to MAX_ID or unchanged.
  - changed=1 only if the value actually differs. No pulse on a saturated step or a locked step.
- **Auto-repeat (REPEAT_DELAY>0):**
  - Hold counter runs while exactly one debounced button is high.
  - One step occurs at REPEAT_DELAY cycles after the press step, then one every REPEAT_RATE cycles.
  - The counter clears on release.
- **Both buttons debounced high:**
  - No steps; both hold counters clear.
  - Releasing one does not generate a step for the other; a new step requires a fresh debounced rising edge.
- **Simultaneous press edges in the same cycle:** no step.
- **lock=1:**
  - Steps are discarded and not queued; debounce and hold counters keep running.
  - Unlocking mid-hold resumes repeat steps on schedule, with no catch-up.
- **Widths:**
  - ID arithmetic is ID_W wide; compare to MAX_ID before incrementing, so there is no overflow.
  - All counters are sized to $clog2 of their max parameter + 1.
- **Timing:** all outputs are registered; data_out is a direct concatenation of registers.

Decomposition:
- Package `target_select_pkg`:
  - default constants (ID_W, CH_W, CHANNEL, DEBOUNCE_CYCLES);
  - typedef `target_id_t`;
  - a `step_dir_t` enum (NONE, UP, DOWN) shared with the command framer.
- One natural sub-module, `button_debouncer`:
  - contains the synchroniser, debounce counter and press/held outputs;
  - parameterised by DEBOUNCE_CYCLES;
  - instantiated twice.
- The top holds the repeat timers, step arbitration and the ID register.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, MIN=1, MAX=20, RESET_ID=1):
- Reset then clean up-press held 6 cycles -> target_id 1->2 exactly 7 edges after the rise; changed pulses once; data_out=0x0B.
- Up pulses of 3 cycles, repeated -> target_id stays 1; changed never asserts.
- From target_id=20, one up press with WRAP=1 -> 1, changed=1. Same with WRAP=0 -> stays 20, changed=0. Down from 1 with WRAP=1 -> 20.
- Up held 25 debounced cycles -> steps at press and at +10, +13, +16, +19, +22: 1->7. Release -> no further steps.
- Both buttons held, then down released while up still held -> no step at any point. lock=1 during an up press -> no change; after lock drops, a fresh press steps.
- rst_n low mid-hold at target_id=9 -> immediately 1; with the button still held through release -> a single step after DEBOUNCE_CYCLES+3 edges.
